// File: rtl/logic_pkg.sv
// ---------------------------------------------------------------------------
// logic_pkg -- shared definitions for the logic_pipe block.
//   OP_W : width of the operation select field
//   op_e : operation encoding driven on the op field of logic_pipe_if
// ---------------------------------------------------------------------------
package logic_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_ANDN   = 3'd6,   // a & ~b
    OP_PASS_A = 3'd7
  } op_e;

endpackage

// File: rtl/logic_pipe_if.sv
// ---------------------------------------------------------------------------
// logic_pipe_if -- handshake/data bundle for logic_pipe.
//   in_valid/in_ready   : input operation handshake
//   op, a, b            : operation select and WIDTH-bit operands
//   out_valid/out_ready : result handshake
//   result, zero, parity: WIDTH-bit result and its flags
// Modports: master (producer/consumer side), slave (the pipeline).
// ---------------------------------------------------------------------------
interface logic_pipe_if #(
  parameter int WIDTH = 64
);
  import logic_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             parity;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, parity
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, parity
  );

endinterface

// File: rtl/logic_pipe_stage.sv
// ---------------------------------------------------------------------------
// logic_pipe_stage -- one elastic register slot with valid/ready.
//   clk, rst : clock, synchronous active-high reset
//   i_valid  : upstream item present         o_ready : this slot advances
//   i_data   : upstream payload (W bits)     o_valid : slot holds an item
//   i_ready  : downstream slot advances      o_data  : slot payload
// The slot advances when it is empty or when the downstream slot advances;
// while it cannot advance its contents are frozen.
// ---------------------------------------------------------------------------
module logic_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_adv;

  assign w_adv   = !r_valid || i_ready;
  assign o_ready = w_adv;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_adv) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/logic_pipe.sv
// ---------------------------------------------------------------------------
// logic_pipe -- elastic pipeline computing a bitwise logic operation.
//   clk  : clock (rising edge)
//   rst  : synchronous active-high reset
//   bus  : logic_pipe_if.slave (in_valid/in_ready, op, a, b,
//          out_valid/out_ready, result, zero, parity)
// Parameters: WIDTH (1..128) operand/result width, STAGES (1..4) depth.
// Optional feature macro LOGIC_PIPE_FLAGS_EN: when defined, zero and parity
// are computed with the result and carried through the pipeline; otherwise
// both outputs are tied low and no flag bits are stored.
// ---------------------------------------------------------------------------
module logic_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  logic_pipe_if.slave  bus
);

`ifdef LOGIC_PIPE_FLAGS_EN
  localparam int PW = WIDTH + 2;   // {parity, zero, result}
`else
  localparam int PW = WIDTH;
`endif

  function automatic logic [WIDTH-1:0] f_logic_op(
    input op_e              op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NAND: return ~(a & b);
      OP_NOR:  return ~(a | b);
      OP_XNOR: return ~(a ^ b);
      OP_ANDN: return a & ~b;
      default: return a;           // OP_PASS_A
    endcase
  endfunction

  logic [WIDTH-1:0] w_res;
  logic [PW-1:0]    w_dat0;
  logic [PW-1:0]    w_out;

  assign w_res = f_logic_op(op_e'(bus.op), bus.a, bus.b);

`ifdef LOGIC_PIPE_FLAGS_EN
  assign w_dat0 = {^w_res, (w_res == '0), w_res};
`else
  assign w_dat0 = w_res;
`endif

  // Each slot gets its own ready/valid nets so the backward ready chain is a
  // set of distinct signals rather than one self-referencing vector.
  for (genvar s = 0; s < STAGES; s++) begin : g_st
    logic          w_vld_in;
    logic          w_rdy_in;
    logic          w_rdy;
    logic          w_vld;
    logic [PW-1:0] w_dat_in;
    logic [PW-1:0] w_dat;

    // ---- stage boundary: slot s input comes from the operation or slot s-1
    if (s == 0) begin : g_first
      assign w_vld_in = bus.in_valid;
      assign w_dat_in = w_dat0;
    end else begin : g_next
      assign w_vld_in = g_st[s-1].w_vld;
      assign w_dat_in = g_st[s-1].w_dat;
    end

    if (s == STAGES - 1) begin : g_last
      assign w_rdy_in = bus.out_ready;
    end else begin : g_inner
      assign w_rdy_in = g_st[s+1].w_rdy;
    end

    logic_pipe_stage #(.W(PW)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_vld_in),
      .o_ready (w_rdy),
      .i_data  (w_dat_in),
      .o_valid (w_vld),
      .i_ready (w_rdy_in),
      .o_data  (w_dat)
    );
  end

  // ---- output boundary
  assign bus.in_ready  = g_st[0].w_rdy;
  assign bus.out_valid = g_st[STAGES-1].w_vld;
  assign w_out         = g_st[STAGES-1].w_dat;
  assign bus.result    = w_out[WIDTH-1:0];

`ifdef LOGIC_PIPE_FLAGS_EN
  assign bus.zero   = w_out[WIDTH];
  assign bus.parity = w_out[WIDTH+1];
`else
  assign bus.zero   = 1'b0;
  assign bus.parity = 1'b0;
`endif

endmodule

// File: doc/logic_pipe.md
LOGIC_PIPE -- requirements
Module: logic_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64, giving the operand and result width in bits; legal range 1..128.
REQ-002 SHALL have parameter STAGES, default 2, giving the number of pipeline register stages; legal range 1..4.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the input operation is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the input this cycle.
REQ-007 SHALL have port op, input, 3 bits: operation select.
REQ-008 SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-009 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port result, output, WIDTH bits: the operation result.
REQ-012 SHALL have port zero, output, 1 bit: result equals all-zero (flag feature).
REQ-013 SHALL have port parity, output, 1 bit: XOR-reduction of result (flag feature).

Function
REQ-014 SHALL encode op as: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (a & ~b), 7 PASS_A; all eight codes are legal.
REQ-015 SHALL apply every operation bitwise per bit index, with no carries and no sign or width extension.
REQ-016 SHALL transfer an input only when in_valid and in_ready are both high on a rising edge.
REQ-017 SHALL transfer an output only when out_valid and out_ready are both high on a rising edge.
REQ-018 SHALL compute the operation combinationally ahead of stage 0; stages 1..STAGES-1 carry the result forward unchanged.
REQ-019 SHALL give a latency of exactly STAGES cycles from input transfer to out_valid when not stalled.
REQ-020 SHALL sustain one transfer per cycle when out_ready is held high.
REQ-021 SHALL advance each stage when its own valid is 0, or when the next stage advances; for the last stage, "next stage advances" means out_ready is high.
REQ-022 SHALL drive in_ready as the stage-0 advance condition, combinational from out_ready through the stall chain, with no dependence on in_valid.
REQ-023 SHALL hold result, zero and parity stable while out_valid is high and out_ready is low.
REQ-024 SHALL never drop or duplicate a transfer under any in_valid/out_ready pattern.
REQ-025 SHALL accept a new input and emit an output in the same cycle when the pipeline is full and out_ready is high.
REQ-026 SHALL be full after STAGES transfers with no outputs; in_ready is then 0 while out_ready is 0.

Reset
REQ-027 SHALL clear all stage valid bits on rst, giving out_valid = 0.
REQ-028 SHALL reset result, zero and parity to 0.
REQ-029 SHALL discard in-flight operations when rst is asserted mid-operation; no output appears for them after reset.
REQ-030 SHALL drive in_ready = 1 in the first cycle after rst deasserts.

Configuration
REQ-031 SHALL support the macro LOGIC_PIPE_FLAGS_EN.
REQ-032 With LOGIC_PIPE_FLAGS_EN defined, SHALL compute zero and parity at stage 0 and pipeline them alongside result.
REQ-033 Without LOGIC_PIPE_FLAGS_EN, SHALL tie zero and parity to constant 0 and instantiate no flag registers; the ports remain present.

Structure
REQ-034 SHALL take the op encoding enum and its width constant from shared package logic_pkg.
REQ-035 SHALL implement each stage as one instance of sub-module logic_pipe_stage: a parametrised-width elastic register with valid/ready.

Verification
REQ-036 SHALL cover: WIDTH=64, STAGES=2, a=0xF0F0_F0F0_F0F0_F0F0, b=0xFF00_FF00_FF00_FF00, ops 0..7 back-to-back with out_ready=1 -> results F000F000F000F000, FFF0FFF0FFF0FFF0, 0FF00FF00FF00FF0, 0FFF0FFF0FFF0FFF, 000F000F000F000F, F00FF00FF00FF00F, 00F000F000F000F0, F0F0F0F0F0F0F0F0, in order, first at cycle 2, one per cycle.
REQ-037 SHALL cover: out_ready=0 while 3 inputs are offered -> exactly 2 accepted, in_ready=0, output held; then out_ready=1 -> outputs drain in order, third input accepted.
REQ-038 SHALL cover: XOR with a=b=0x1234 (WIDTH=16, flags on) -> result 0, zero=1, parity=0; a=0x0001, b=0 OR -> zero=0, parity=1.
REQ-039 SHALL cover: rst asserted with 2 items in flight -> out_valid=0 the next cycle, result=0, neither item ever emitted.
REQ-040 SHALL cover: random in_valid/out_ready at 50%, STAGES=1..4, WIDTH=1 and 128 -> scoreboard matches in order, no loss or duplication.
REQ-041 SHALL cover: build without LOGIC_PIPE_FLAGS_EN -> zero=parity=0 for every result, including result=0.
